bytemask_ram_pipe: RTL and testbench



---
 rtl/bytemask_ram_pipe.sv | 181 ++++++++++++++++++
 tb/tb_bytemask_ram_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bytemask_ram_pipe.sv
// bytemask_ram_pipe: byte-masked single-port word RAM behind a valid/ready
// request port, with a read pipeline and a credit-guarded response FIFO.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (accept when both are 1)
//   req_wr                1 = write, 0 = read
//   req_addr              word address (>= DEPTH is out of range)
//   req_mask              per-byte write enable, bit i -> bits [8i+7:8i]
//   req_wdata             write data
//   rsp_valid/rsp_ready   read response handshake
//   rsp_rdata             read data (holds last value while rsp_valid=0)
//   rsp_err               response belongs to an out-of-range read
//   wr_err                sticky: an out-of-range write was dropped
//
// Reads see the array RD_LAT cycles after acceptance. The credit counter
// reserves a FIFO slot for each read before it is accepted, so the FIFO can
// never overflow and rsp_ready=1 gives one read per cycle without bubbles.

// One byte lane of the array: synchronous write, asynchronous read.
module bytemask_lane #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wbyte,
    output logic [7:0]        rbyte
);
    // Contents are never reset so they survive rst_n.
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wbyte;
    end

    assign rbyte = mem[addr];
endmodule

module bytemask_ram_pipe #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W/8-1:0] req_mask,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                wr_err
);
    localparam int NB     = DATA_W / 8;
    localparam int STAGES = RD_LAT - 1;      // registers between array and FIFO
    localparam int FD     = RD_LAT + 1;      // response FIFO depth
    localparam int PW     = $clog2(FD);
    localparam int CW     = $clog2(FD + 1);

    logic acc, rd_acc, wr_acc, in_rng, pop;
    logic [CW-1:0] credit;

    assign in_rng = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);
    // Gating with rst_n keeps ready low for the whole reset window.
    assign req_ready = rst_n & (credit != '0);
    assign acc    = req_valid & req_ready;
    assign rd_acc = acc & ~req_wr;
    assign wr_acc = acc & req_wr;

    // ---------------- array ----------------
    logic [NB-1:0][7:0] rd_word;

    for (genvar i = 0; i < NB; i++) begin : g_lane
        bytemask_lane #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lane (
            .clk   (clk),
            .we    (wr_acc & in_rng & req_mask[i]),
            .addr  (req_addr),
            .wbyte (req_wdata[8*i +: 8]),
            .rbyte (rd_word[i])
        );
    end

    // Out-of-range reads carry zero data and the error flag down the pipe.
    logic [DATA_W-1:0] rd_dat0;
    logic              rd_err0;
    assign rd_dat0 = in_rng ? rd_word : '0;
    assign rd_err0 = ~in_rng;

    // ---------------- read pipeline ----------------
    logic              push;
    logic [DATA_W-1:0] push_dat;
    logic              push_err;

    if (STAGES == 0) begin : g_lat1
        // Array data is captured straight into the FIFO at the accepting edge.
        assign push     = rd_acc;
        assign push_dat = rd_dat0;
        assign push_err = rd_err0;
    end else begin : g_latn
        logic [STAGES:1]   vld_pipe;
        logic [STAGES:1]   err_pipe;
        logic [DATA_W-1:0] dat_pipe [1:STAGES];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_pipe <= '0;
            end else begin
                vld_pipe[1] <= rd_acc;
                for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
            end
        end

        always_ff @(posedge clk) begin
            dat_pipe[1] <= rd_dat0;
            err_pipe[1] <= rd_err0;
            for (int k = 2; k <= STAGES; k++) begin
                dat_pipe[k] <= dat_pipe[k-1];
                err_pipe[k] <= err_pipe[k-1];
            end
        end

        assign push     = vld_pipe[STAGES];
        assign push_dat = dat_pipe[STAGES];
        assign push_err = err_pipe[STAGES];
    end

    // ---------------- response FIFO ----------------
    logic [DATA_W-1:0] fifo_dat [FD];
    logic [FD-1:0]     fifo_err;
    logic [PW-1:0]     wptr, rptr;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] last_dat;

    assign rsp_valid = (cnt != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_rdata = rsp_valid ? fifo_dat[rptr] : last_dat;
    assign rsp_err   = rsp_valid & fifo_err[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dat[wptr] <= push_dat;
            fifo_err[wptr] <= push_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            credit   <= CW'(FD);
            last_dat <= '0;
            wr_err   <= 1'b0;
        end else begin
            if (push) wptr <= (wptr == PW'(FD-1)) ? '0 : wptr + 1'b1;
            if (pop) begin
                rptr     <= (rptr == PW'(FD-1)) ? '0 : rptr + 1'b1;
                last_dat <= fifo_dat[rptr];
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
            // Credit = free FIFO slots minus reads still heading for them.
            case ({rd_acc, pop})
                2'b10:   credit <= credit - 1'b1;
                2'b01:   credit <= credit + 1'b1;
                default: ;
            endcase
            if (wr_acc && !in_rng) wr_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bytemask_ram_pipe.sv
module tb_bytemask_ram_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Index 0: RD_LAT=1, index 1: RD_LAT=2; both DEPTH=200.
    logic [1:0]       req_valid, req_wr, rsp_ready;
    logic [1:0][7:0]  req_addr;
    logic [1:0][3:0]  req_mask;
    logic [1:0][31:0] req_wdata;
    wire  [1:0]       req_ready, rsp_valid, rsp_err, wr_err;
    wire  [1:0][31:0] rsp_rdata;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bytemask_ram_pipe #(.DATA_W(32), .DEPTH(200), .ADDR_W(8), .RD_LAT(g+1)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_wr    (req_wr[g]),
            .req_addr  (req_addr[g]),
            .req_mask  (req_mask[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .wr_err    (wr_err[g])
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer one request, wait (bounded) for ready, return #1 after acceptance.
    task automatic do_req(int d, bit wr, logic [7:0] a, logic [3:0] m, logic [31:0] w);
        int n = 0;
        req_valid[d] = 1'b1;
        req_wr[d]    = wr;
        req_addr[d]  = a;
        req_mask[d]  = m;
        req_wdata[d] = w;
        while (!req_ready[d] && n < 20) begin
            cyc();
            n++;
        end
        if (!req_ready[d]) chk("req_ready_wait", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic wr_op(int d, logic [7:0] a, logic [3:0] m, logic [31:0] w, bit exp_werr);
        do_req(d, 1'b1, a, m, w);
        chk("wr_err", 32'(wr_err[d]), 32'(exp_werr));
        for (int k = 0; k <= d; k++) begin
            chk("wr_no_rsp", 32'(rsp_valid[d]), 32'd0);
            cyc();
        end
    endtask

    // Response must appear exactly d+1 cycles after acceptance (rsp_ready=1).
    task automatic rd_chk(int d, logic [7:0] a, logic [31:0] exp, bit exp_err);
        do_req(d, 1'b0, a, 4'h0, 32'h0);
        for (int k = 0; k < d; k++) begin
            chk("rd_early", 32'(rsp_valid[d]), 32'd0);
            cyc();
        end
        chk("rd_valid", 32'(rsp_valid[d]), 32'd1);
        chk("rd_data", rsp_rdata[d], exp);
        chk("rd_err", 32'(rsp_err[d]), 32'(exp_err));
        cyc();
        chk("rd_popped", 32'(rsp_valid[d]), 32'd0);
        chk("idle_err", 32'(rsp_err[d]), 32'd0);
        chk("rd_hold", rsp_rdata[d], exp);
    endtask

    typedef struct {
        int          d;
        bit          wr;
        logic [7:0]  addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          exp_werr;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // d, wr, addr, mask, wdata, exp_rdata, exp_err, exp_werr
        vecs.push_back('{0, 1, 8'd5,   4'hF, 32'hAABBCCDD, 32'h0,        0, 0});
        vecs.push_back('{0, 1, 8'd5,   4'h5, 32'h11223344, 32'h0,        0, 0});
        vecs.push_back('{0, 0, 8'd5,   4'h0, 32'h0,        32'hAA22CC44, 0, 0});
        vecs.push_back('{0, 1, 8'd9,   4'hF, 32'h12345678, 32'h0,        0, 0});
        vecs.push_back('{0, 1, 8'd9,   4'h0, 32'hFFFFFFFF, 32'h0,        0, 0});
        vecs.push_back('{0, 0, 8'd9,   4'h0, 32'h0,        32'h12345678, 0, 0});
        vecs.push_back('{0, 1, 8'd0,   4'hF, 32'h00000000, 32'h0,        0, 0});
        vecs.push_back('{0, 1, 8'd0,   4'hA, 32'h11223344, 32'h0,        0, 0});
        vecs.push_back('{0, 0, 8'd0,   4'h0, 32'h0,        32'h11003300, 0, 0});
        vecs.push_back('{0, 1, 8'd199, 4'hF, 32'hCAFEF00D, 32'h0,        0, 0});
        vecs.push_back('{0, 0, 8'd199, 4'h0, 32'h0,        32'hCAFEF00D, 0, 0});
        vecs.push_back('{0, 1, 8'd250, 4'hF, 32'hDEADBEEF, 32'h0,        0, 1});
        vecs.push_back('{0, 0, 8'd250, 4'h0, 32'h0,        32'h00000000, 1, 1});
        vecs.push_back('{0, 1, 8'd200, 4'h3, 32'hFFFFFFFF, 32'h0,        0, 1});
        vecs.push_back('{0, 0, 8'd200, 4'h0, 32'h0,        32'h00000000, 1, 1});
        vecs.push_back('{0, 0, 8'd199, 4'h0, 32'h0,        32'hCAFEF00D, 0, 1});
        vecs.push_back('{0, 0, 8'd5,   4'h0, 32'h0,        32'hAA22CC44, 0, 1});
        vecs.push_back('{1, 1, 8'd3,   4'hF, 32'hA5A5A5A5, 32'h0,        0, 0});
        vecs.push_back('{1, 1, 8'd3,   4'h2, 32'h5A5A5A5A, 32'h0,        0, 0});
        vecs.push_back('{1, 0, 8'd3,   4'h0, 32'h0,        32'hA5A55AA5, 0, 0});
        vecs.push_back('{1, 1, 8'd255, 4'hF, 32'h00000001, 32'h0,        0, 1});
        vecs.push_back('{1, 0, 8'd255, 4'h0, 32'h0,        32'h00000000, 1, 1});
        vecs.push_back('{1, 0, 8'd3,   4'h0, 32'h0,        32'hA5A55AA5, 0, 1});

        req_valid = '0; req_wr = '0; req_addr = '0; req_mask = '0; req_wdata = '0;
        rsp_ready = 2'b11;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", 32'(req_ready[d]), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_rsp_err",   32'(rsp_err[d]),   32'd0);
            chk("rst_wr_err",    32'(wr_err[d]),    32'd0);
            chk("rst_rsp_rdata", rsp_rdata[d],      32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst0", 32'(req_ready[0]), 32'd1);
        chk("ready_after_rst1", 32'(req_ready[1]), 32'd1);
        cyc();

        // Table-driven vectors
        foreach (vecs[i]) begin
            if (vecs[i].wr)
                wr_op(vecs[i].d, vecs[i].addr, vecs[i].mask, vecs[i].wdata, vecs[i].exp_werr);
            else
                rd_chk(vecs[i].d, vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // RD_LAT=2 back-to-back reads of 0..7, preloaded with value = addr
        for (int a = 0; a < 8; a++) wr_op(1, 8'(a), 4'hF, 32'(a), 1'b1);
        for (int c = 0; c < 11; c++) begin
            req_valid[1] = (c < 8);
            req_wr[1]    = 1'b0;
            req_addr[1]  = 8'(c);
            if (c < 8) chk("b2b_ready", 32'(req_ready[1]), 32'd1);
            chk("b2b_valid", 32'(rsp_valid[1]), 32'((c >= 2) && (c < 10)));
            if (c >= 2 && c < 10) chk("b2b_data", rsp_rdata[1], 32'(c - 2));
            cyc();
        end
        req_valid[1] = 1'b0;

        // RD_LAT=1 back-pressure: only two reads fit, then ready drops
        rsp_ready[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            req_valid[0] = 1'b1;
            req_wr[0]    = 1'b0;
            req_addr[0]  = (c == 0) ? 8'd5 : 8'd9;
            chk("bp_ready", 32'(req_ready[0]), 32'(c < 2));
            if (c >= 1) begin
                chk("bp_valid_hold", 32'(rsp_valid[0]), 32'd1);
                chk("bp_data_hold",  rsp_rdata[0], 32'hAA22CC44);
            end
            cyc();
        end
        req_valid[0] = 1'b0;
        chk("bp_ready_low", 32'(req_ready[0]), 32'd0);
        rsp_ready[0] = 1'b1;
        cyc();
        chk("bp_second_valid", 32'(rsp_valid[0]), 32'd1);
        chk("bp_second_data",  rsp_rdata[0], 32'h12345678);
        chk("bp_ready_resume", 32'(req_ready[0]), 32'd1);
        cyc();
        chk("bp_drained", 32'(rsp_valid[0]), 32'd0);
        rd_chk(0, 8'd9, 32'h12345678, 1'b0);

        // Reset with two RD_LAT=2 reads in flight
        rsp_ready[1] = 1'b0;
        do_req(1, 1'b0, 8'd3, 4'h0, 32'h0);
        do_req(1, 1'b0, 8'd7, 4'h0, 32'h0);
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        rsp_ready[1] = 1'b1;
        chk("rst_clears_wr_err", 32'(wr_err[0]), 32'd0);
        for (int c = 0; c < 5; c++) begin
            chk("no_rsp_after_rst1", 32'(rsp_valid[1]), 32'd0);
            chk("no_rsp_after_rst0", 32'(rsp_valid[0]), 32'd0);
            cyc();
        end
        rd_chk(1, 8'd3, 32'h00000003, 1'b0);
        rd_chk(0, 8'd9, 32'h12345678, 1'b0);
        rd_chk(0, 8'd199, 32'hCAFEF00D, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
